// File: rtl/fp_operand_unpack_if.sv
// Handshake/bus bundle for fp_operand_unpack: operand pair in, unpacked fields out.
// EXP_SIZE / MANTIS_SIZE default from the `EXP_SIZE / `MANTIS_SIZE macros when defined.
`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

interface fp_operand_unpack_if #(
    parameter int EXP_SIZE    = `EXP_SIZE,
    parameter int MANTIS_SIZE = `MANTIS_SIZE
);
    localparam int W = 1 + EXP_SIZE + MANTIS_SIZE;

    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0]           in_A;
    logic [W-1:0]           in_B;
    logic                   op_sub;
    logic                   out_valid;
    logic                   out_ready;
    logic                   sign_A;
    logic                   sign_B;
    logic [EXP_SIZE-1:0]    exp_A;
    logic [EXP_SIZE-1:0]    exp_B;
    logic [MANTIS_SIZE-1:0] mantis_A;
    logic [MANTIS_SIZE-1:0] mantis_B;
    logic [2:0]             type_A;
    logic [2:0]             type_B;

    modport master (
        output in_valid, in_A, in_B, op_sub, out_ready,
        input  in_ready, out_valid, sign_A, sign_B, exp_A, exp_B,
               mantis_A, mantis_B, type_A, type_B
    );

    modport slave (
        input  in_valid, in_A, in_B, op_sub, out_ready,
        output in_ready, out_valid, sign_A, sign_B, exp_A, exp_B,
               mantis_A, mantis_B, type_A, type_B
    );
endinterface

// File: rtl/fp_operand_unpack.sv
// FP add/sub operand unpack stage: splits and classifies an operand pair into registered fields.
// FP_UNPACK_SKID_EN adds a one-entry skid register so in_ready is registered.
`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

module fp_operand_unpack #(
    parameter int EXP_SIZE    = `EXP_SIZE,
    parameter int MANTIS_SIZE = `MANTIS_SIZE
) (
    input logic              clk,
    input logic              rst,
    fp_operand_unpack_if.slave bus
);
    localparam int W = 1 + EXP_SIZE + MANTIS_SIZE;

    typedef enum logic [2:0] {
        T_ZERO      = 3'b000,
        T_INF       = 3'b001,
        T_SUBNORMAL = 3'b010,
        T_NORMAL    = 3'b011,
        T_NAN       = 3'b100
    } fp_type_e;

    typedef struct packed {
        logic                   sign_a;
        logic [EXP_SIZE-1:0]    exp_a;
        logic [MANTIS_SIZE-1:0] mant_a;
        fp_type_e               type_a;
        logic                   sign_b;
        logic [EXP_SIZE-1:0]    exp_b;
        logic [MANTIS_SIZE-1:0] mant_b;
        fp_type_e               type_b;
    } fields_t;

    function automatic fp_type_e classify(input logic [EXP_SIZE-1:0]    e,
                                          input logic [MANTIS_SIZE-1:0] m);
        fp_type_e t;
        if (e == '0)
            t = (m == '0) ? T_ZERO : T_SUBNORMAL;
        else if (e == '1)
            t = (m == '0) ? T_INF : T_NAN;
        else
            t = T_NORMAL;
        return t;
    endfunction

    fields_t in_fields;
    fields_t main_q;
    logic    main_valid_q;
    logic    in_ready_w;
    logic    accept;
    logic    consume;

    always_comb begin
        in_fields        = '0;
        in_fields.sign_a = bus.in_A[W-1];
        in_fields.exp_a  = bus.in_A[W-2:MANTIS_SIZE];
        in_fields.mant_a = bus.in_A[MANTIS_SIZE-1:0];
        in_fields.type_a = classify(in_fields.exp_a, in_fields.mant_a);
        in_fields.exp_b  = bus.in_B[W-2:MANTIS_SIZE];
        in_fields.mant_b = bus.in_B[MANTIS_SIZE-1:0];
        in_fields.type_b = classify(in_fields.exp_b, in_fields.mant_b);
        // Subtraction folds into B's sign; a NaN keeps its payload sign untouched.
        in_fields.sign_b = (in_fields.type_b == T_NAN) ? bus.in_B[W-1]
                                                       : (bus.in_B[W-1] ^ bus.op_sub);
    end

    assign accept  = bus.in_valid && in_ready_w;
    assign consume = main_valid_q && bus.out_ready;

`ifdef FP_UNPACK_SKID_EN
    fields_t skid_q;
    logic    skid_valid_q;

    assign in_ready_w = !skid_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else if (!main_valid_q || consume) begin
            // Main frees up: drain skid first to keep FIFO order; accept is blocked while skid is full.
            if (skid_valid_q) begin
                main_q       <= skid_q;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                main_q       <= in_fields;
                main_valid_q <= 1'b1;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= in_fields;
            skid_valid_q <= 1'b1;
        end
    end
`else
    assign in_ready_w = !main_valid_q || bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
        end else if (accept) begin
            main_q       <= in_fields;
            main_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            main_valid_q <= 1'b0;
        end
    end
`endif

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = main_valid_q;
    assign bus.sign_A    = main_q.sign_a;
    assign bus.exp_A     = main_q.exp_a;
    assign bus.mantis_A  = main_q.mant_a;
    assign bus.type_A    = main_q.type_a;
    assign bus.sign_B    = main_q.sign_b;
    assign bus.exp_B     = main_q.exp_b;
    assign bus.mantis_B  = main_q.mant_b;
    assign bus.type_B    = main_q.type_b;
endmodule

// File: tb/tb_fp_operand_unpack.sv
// Self-checking bench for fp_operand_unpack (single precision) against a queue-based reference model.
module tb_fp_operand_unpack;
    localparam int E = 8;
    localparam int M = 23;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_operand_unpack_if #(.EXP_SIZE(E), .MANTIS_SIZE(M)) bus ();
    fp_operand_unpack #(.EXP_SIZE(E), .MANTIS_SIZE(M)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        sa;
        logic [7:0]  ea;
        logic [22:0] ma;
        logic [2:0]  ta;
        logic        sb;
        logic [7:0]  eb;
        logic [22:0] mb;
        logic [2:0]  tb;
    } fields_t;

    int checks = 0;
    int errors = 0;

    fields_t     expq[$];
    logic        m_rdy, m_ov;
    fields_t     m_front;
    logic        d_v, d_ordy, d_sub;
    logic [31:0] d_a, d_b;

    function automatic logic [2:0] ref_class(input logic [31:0] x);
        int unsigned e = (x >> 23) & 32'hFF;
        int unsigned m = x & 32'h7F_FFFF;
        if (e == 0)   return (m == 0) ? 3'd0 : 3'd2;
        if (e == 255) return (m == 0) ? 3'd1 : 3'd4;
        return 3'd3;
    endfunction

    function automatic fields_t ref_unpack(input logic [31:0] a, input logic [31:0] b, input logic sub);
        fields_t f;
        f.sa = a[31]; f.ea = a[30:23]; f.ma = a[22:0]; f.ta = ref_class(a);
        f.eb = b[30:23]; f.mb = b[22:0]; f.tb = ref_class(b);
        f.sb = (f.tb == 3'd4) ? b[31] : (b[31] ^ sub);
        return f;
    endfunction

    function automatic fields_t observed();
        return {bus.sign_A, bus.exp_A, bus.mantis_A, bus.type_A,
                bus.sign_B, bus.exp_B, bus.mantis_B, bus.type_B};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] m;
        case ($urandom_range(0, 3))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            default: e = 8'($urandom);
        endcase
        m = ($urandom_range(0, 1) == 0) ? 23'h0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    // Drive one cycle's inputs (called at posedge+1) and derive the model's view of this cycle.
    task automatic apply(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic ordy);
        d_v = v; d_a = a; d_b = b; d_sub = sub; d_ordy = ordy;
        bus.in_valid = v; bus.in_A = a; bus.in_B = b; bus.op_sub = sub; bus.out_ready = ordy;
`ifdef FP_UNPACK_SKID_EN
        m_rdy = (expq.size() < 2);
`else
        m_rdy = (expq.size() == 0) || ordy;
`endif
        m_ov    = (expq.size() > 0);
        m_front = m_ov ? expq[0] : '0;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        if (m_ov && d_ordy) void'(expq.pop_front());
        if (d_v && m_rdy) expq.push_back(ref_unpack(d_a, d_b, d_sub));
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_A = '0; bus.in_B = '0; bus.op_sub = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (observed() !== fields_t'('0)) begin errors++; $display("FAIL reset_fields got %h want 0", observed()); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        rst = 1'b0;
        apply(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b want 0", bus.out_valid); end
        advance();
    endtask

    task automatic test_classify();
        logic [31:0] va[3], vb[3];
        logic        vs[3];
        va[0] = 32'h3F80_0000; vb[0] = 32'h4000_0000; vs[0] = 1'b0;
        va[1] = 32'h8000_0000; vb[1] = 32'h0000_0001; vs[1] = 1'b1;
        va[2] = 32'hFF80_0000; vb[2] = 32'h7FC0_0000; vs[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) apply(1'b1, va[i], vb[i], vs[i], 1'b1);
            else       apply(1'b0, '0, '0, 1'b0, 1'b1);
            checks++;
            if (bus.in_ready !== m_rdy) begin errors++; $display("FAIL cls_in_ready[%0d] got %b want %b", i, bus.in_ready, m_rdy); end
            if (i > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL cls_out_valid[%0d] got %b want 1", i, bus.out_valid); end
                checks++;
                if (observed() !== m_front) begin errors++; $display("FAIL cls_fields[%0d] got %h want %h", i, observed(), m_front); end
            end
            if (i == 1) begin
                checks++;
                if ({bus.exp_A, bus.mantis_A, bus.type_A, bus.exp_B, bus.type_B, bus.sign_B} !==
                    {8'h7F, 23'h0, 3'b011, 8'h80, 3'b011, 1'b0}) begin
                    errors++; $display("FAIL cls_one_two got %h/%h/%h/%h/%h/%b want 7f/0/3/80/3/0",
                                       bus.exp_A, bus.mantis_A, bus.type_A, bus.exp_B, bus.type_B, bus.sign_B);
                end
            end
            if (i == 2) begin
                checks++;
                if ({bus.sign_A, bus.type_A, bus.type_B, bus.mantis_B, bus.sign_B} !==
                    {1'b1, 3'b000, 3'b010, 23'h1, 1'b1}) begin
                    errors++; $display("FAIL cls_zero_sub got %b/%h/%h/%h/%b want 1/0/2/1/1",
                                       bus.sign_A, bus.type_A, bus.type_B, bus.mantis_B, bus.sign_B);
                end
            end
            if (i == 3) begin
                checks++;
                if ({bus.sign_A, bus.type_A, bus.type_B, bus.mantis_B, bus.sign_B} !==
                    {1'b1, 3'b001, 3'b100, 23'h40_0000, 1'b0}) begin
                    errors++; $display("FAIL cls_inf_nan got %b/%h/%h/%h/%b want 1/1/4/400000/0",
                                       bus.sign_A, bus.type_A, bus.type_B, bus.mantis_B, bus.sign_B);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa[3], pb[3];
        logic        ps[3];
        int          idx = 0;
        int          n_out = 0;
        int          want_idx;
        logic        acc;
        for (int i = 0; i < 3; i++) begin pa[i] = rand_op(); pb[i] = rand_op(); ps[i] = 1'($urandom); end
        apply(1'b0, '0, '0, 1'b0, 1'b1);
        advance();
        for (int c = 0; c < 14; c++) begin
            logic ordy = (c >= 4);
            if (idx < 3) apply(1'b1, pa[idx], pb[idx], ps[idx], ordy);
            else         apply(1'b0, '0, '0, 1'b0, ordy);
            checks++;
            if (bus.in_ready !== m_rdy) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want %b", c, bus.in_ready, m_rdy); end
            checks++;
            if (bus.out_valid !== m_ov) begin errors++; $display("FAIL bp_out_valid[%0d] got %b want %b", c, bus.out_valid, m_ov); end
            if (m_ov) begin
                checks++;
                if (observed() !== m_front) begin errors++; $display("FAIL bp_fields[%0d] got %h want %h", c, observed(), m_front); end
            end
            if (m_ov && ordy) n_out++;
            acc = (idx < 3) && m_rdy;
            advance();
            if (acc) idx++;
            if (c == 3) begin
`ifdef FP_UNPACK_SKID_EN
                want_idx = 2;
`else
                want_idx = 1;
`endif
                checks++;
                if (idx !== want_idx) begin errors++; $display("FAIL bp_accepted got %0d want %0d", idx, want_idx); end
            end
        end
        checks++;
        if (n_out !== 3) begin errors++; $display("FAIL bp_outputs got %0d want 3", n_out); end
    endtask

    task automatic test_reset_mid();
        apply(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
        advance();
        apply(1'b1, rand_op(), rand_op(), 1'b1, 1'b0);
        advance();
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b want 1", bus.out_valid); end
        #1 rst = 1'b1;
        #1;
        expq.delete();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (observed() !== fields_t'('0)) begin errors++; $display("FAIL rstmid_fields got %h want 0", observed()); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", bus.in_ready); end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, '0, '0, 1'b0, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost[%0d] got %b want 0", c, bus.out_valid); end
            advance();
        end
    endtask

    task automatic test_stream();
        int n_out = 0;
        for (int i = 0; i <= 100; i++) begin
            if (i < 100) apply(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b1);
            else         apply(1'b0, '0, '0, 1'b0, 1'b1);
            checks++;
            if (bus.in_ready !== m_rdy) begin errors++; $display("FAIL stream_in_ready[%0d] got %b want %b", i, bus.in_ready, m_rdy); end
            checks++;
            if (bus.out_valid !== (i > 0)) begin errors++; $display("FAIL stream_out_valid[%0d] got %b want %b", i, bus.out_valid, (i > 0)); end
            if (m_ov) begin
                n_out++;
                checks++;
                if (observed() !== m_front) begin errors++; $display("FAIL stream_fields[%0d] got %h want %h", i, observed(), m_front); end
            end
            advance();
        end
        checks++;
        if (n_out !== 100) begin errors++; $display("FAIL stream_count got %0d want 100", n_out); end
        apply(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", bus.out_valid); end
        advance();
    endtask

    initial begin
        test_reset();
        test_classify();
        test_backpressure();
        test_reset_mid();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_operand_unpack.md
Name: fp_operand_unpack

Overview:
- Pipeline stage directly upstream of the special-case detector in the FP add/sub datapath.
- Accepts a packed operand pair plus an add/sub opcode through a valid/ready handshake.
- Splits each operand into sign/exponent/mantissa, classifies it as ZERO/INF/SUBNORMAL/NORMAL/NAN, and presents registered fields and type codes downstream.
- Absorbs downstream backpressure without losing data.

Parameters:
- EXP_SIZE, `EXP_SIZE (8): exponent field width.
- MANTIS_SIZE, `MANTIS_SIZE (23): stored mantissa width; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input pair valid.
- in_ready  output  1  stage can accept an input pair.
- in_A  input  1+EXP_SIZE+MANTIS_SIZE  packed operand A.
- in_B  input  1+EXP_SIZE+MANTIS_SIZE  packed operand B.
- op_sub  input  1  1 = A-B, 0 = A+B.
- out_valid  output  1  output fields valid.
- out_ready  input  1  downstream accepts output.
- sign_A, sign_B  output  1 each  unpacked signs (sign_B effective, see below).
- exp_A, exp_B  output  EXP_SIZE each  exponent fields.
- mantis_A, mantis_B  output  MANTIS_SIZE each  mantissa fields.
- type_A, type_B  output  3 each  type codes.

Behaviour:
- Type codes:
  - ZERO=3'b000
  - INF=3'b001
  - SUBNORMAL=3'b010
  - NORMAL=3'b011
  - NAN=3'b100
- Classification:
  - exp==0 and mant==0 -> ZERO.
  - exp==0 and mant!=0 -> SUBNORMAL.
  - exp all-ones and mant==0 -> INF.
  - exp all-ones and mant!=0 -> NAN.
  - Otherwise NORMAL.
- Effective sign_B:
  - B's sign XOR op_sub when type_B != NAN.
  - NaN sign is passed unmodified.
- Output fields come only from registers; there is no combinational path from in_* to out fields.
- Handshake:
  - A transfer occurs on any edge where valid && ready.
  - out_valid, once high, and all output fields stay stable until out_ready is high.
- Main register (out_*):
  - Loads when empty, or when its contents are consumed in the same cycle.
  - Latency is 1 cycle: a pair accepted at edge N is visible after edge N with out_valid=1.
- Reset:
  - out_valid=0; all output fields 0 (type codes read 3'b000).
  - in_ready=1 after reset, or per the macro's rule (see Optional Feature).
  - Reset mid-transfer discards all held pairs; no partial output.
- Simultaneous accept and consume: throughput is one pair per cycle, with no bubble.
- in_valid low: state holds. in_A, in_B and op_sub are don't-care.

Optional Feature:
- Macro: FP_UNPACK_SKID_EN.
- Defined:
  - A one-entry skid register is added; in_ready = !skid_valid (registered, no combinational dependence on out_ready).
  - If out_valid && !out_ready and an input is accepted, the classified pair goes to skid and skid_valid=1.
  - On the next consume, skid moves to main and skid_valid clears.
  - Order is strictly FIFO. Max occupancy is 2.
  - skid_valid resets to 0.
- Undefined:
  - No skid register; in_ready = !out_valid || out_ready (combinational).
  - Max occupancy is 1. Full throughput holds only while out_ready stays high.

Test Plan:
- Reset, then in_A=0x3F800000, in_B=0x40000000, op_sub=0, out_ready=1.
  - Next cycle: out_valid=1, exp_A=0x7F, mantis_A=0, type_A=NORMAL, exp_B=0x80, type_B=NORMAL, sign_B=0.
- in_A=0x80000000, in_B=0x00000001, op_sub=1.
  - Expect sign_A=1, type_A=ZERO, type_B=SUBNORMAL, mantis_B=1, sign_B=1.
- in_A=0xFF800000, in_B=0x7FC00000, op_sub=1.
  - Expect type_A=INF, sign_A=1, type_B=NAN, sign_B=0 (NaN sign not flipped), mantis_B=0x400000.
- out_ready=0 with three back-to-back valid pairs P1, P2, P3.
  - SKID_EN: P1 and P2 accepted, in_ready=0 for P3, outputs stable.
  - Non-SKID: only P1 accepted.
  - Release out_ready: P1, P2, P3 emerge in order, none lost or duplicated.
- Assert rst for 1 cycle while out_valid=1 and out_ready=0.
  - out_valid=0 and fields 0 immediately (asynchronous); held pairs never appear.
- Streaming 100 random pairs with out_ready=1 and in_valid=1.
  - One output per cycle after the first.
  - Fields match a reference classifier.
